// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, states, ALU ops, instruction layout.
package control_fsm_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned IMM_W   = 19;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_ORR = 4'd3;
  localparam logic [OP_W-1:0] OP_MOV = 4'd4;
  localparam logic [OP_W-1:0] OP_LDR = 4'd5;
  localparam logic [OP_W-1:0] OP_STR = 4'd6;
  localparam logic [OP_W-1:0] OP_B   = 4'd7;
  localparam logic [OP_W-1:0] OP_BL  = 4'd8;
  localparam logic [OP_W-1:0] OP_NOP = 4'd9;

  localparam logic [ALU_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND    = 3'b010;
  localparam logic [ALU_W-1:0] ALU_ORR    = 3'b011;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 3'b100;

  // R7 is the program counter in the register file.
  localparam logic [REG_W-1:0] PC_REG = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_MOV = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_BL  = 3'd5,
    CLS_NOP = 3'd6,
    CLS_ILL = 3'd7
  } op_class_t;

  // Field layout of the 32-bit instruction word, MSB first.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/control_fsm_op_decoder.sv
// Combinational opcode classifier and ALU operation select.
module op_decoder
  import control_fsm_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output op_class_t        op_class_c,
  output logic [ALU_W-1:0] alu_op_c
);

  // Map opcode to instruction class and the ALU op it needs in EXECUTE.
  always_comb begin
    op_class_c = CLS_ILL;
    alu_op_c   = ALU_ADD;
    case (op)
      OP_ADD: begin op_class_c = CLS_ALU; alu_op_c = ALU_ADD;    end
      OP_SUB: begin op_class_c = CLS_ALU; alu_op_c = ALU_SUB;    end
      OP_AND: begin op_class_c = CLS_ALU; alu_op_c = ALU_AND;    end
      OP_ORR: begin op_class_c = CLS_ALU; alu_op_c = ALU_ORR;    end
      OP_MOV: begin op_class_c = CLS_MOV; alu_op_c = ALU_PASS_B; end
      OP_LDR: op_class_c = CLS_LD;
      OP_STR: op_class_c = CLS_ST;
      OP_B:   op_class_c = CLS_BR;
      OP_BL:  op_class_c = CLS_BL;
      OP_NOP: op_class_c = CLS_NOP;
      default: op_class_c = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with IR.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        instr,
  input  logic                mem_ready,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                WE,
  output logic                LRWrite,
  output logic [REG_W-1:0]    Add1,
  output logic [REG_W-1:0]    Add2,
  output logic [REG_W-1:0]    Add3,
  output logic [ALU_W-1:0]    ALUOp,
  output logic                ALUSrcB,
  output logic                ResultSrc,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_t           cur_state;
  state_t           nxt_state;
  logic [W-1:0]     ir;
  instr_fields_t    fields;
  op_class_t        op_class;
  logic [ALU_W-1:0] dec_alu_op;
  logic             unused_imm;

  assign fields     = instr_fields_t'(ir[31:0]);
  assign unused_imm = ^fields.imm;
  assign state      = cur_state;

  op_decoder u_op_decoder (
    .op         (fields.op),
    .op_class_c (op_class),
    .alu_op_c   (dec_alu_op)
  );

  // State and instruction register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_FETCH;
      ir        <= '0;
    end else begin
      cur_state <= nxt_state;
      if (IRWrite) ir <= instr;
    end
  end

  // Next-state and control strobes from state, IR class and memory handshake.
  always_comb begin
    nxt_state = cur_state;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    WE        = 1'b0;
    LRWrite   = 1'b0;
    illegal   = 1'b0;
    Add1      = fields.rs1;
    Add2      = (op_class == CLS_ST) ? fields.rd : fields.rs2;
    Add3      = fields.rd;
    ALUOp     = ALU_ADD;
    ALUSrcB   = 1'b0;
    ResultSrc = 1'b0;

    case (cur_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nxt_state = ST_DECODE;
        end
      end

      ST_DECODE: nxt_state = ST_EXECUTE;

      ST_EXECUTE: begin
        case (op_class)
          CLS_ALU: begin
            ALUOp     = dec_alu_op;
            nxt_state = ST_WRITEBACK;
          end
          CLS_MOV: begin
            ALUOp     = dec_alu_op;
            ALUSrcB   = 1'b1;
            nxt_state = ST_WRITEBACK;
          end
          CLS_LD, CLS_ST: begin
            ALUSrcB   = 1'b1;
            nxt_state = ST_MEMORY;
          end
          CLS_BR, CLS_BL: begin
            Add1      = PC_REG;
            ALUSrcB   = 1'b1;
            PCWrite   = 1'b1;
            PCSrc     = 1'b1;
            LRWrite   = (op_class == CLS_BL);
            nxt_state = ST_FETCH;
          end
          CLS_NOP: nxt_state = ST_FETCH;
          default: begin
            illegal   = 1'b1;
            nxt_state = ST_FETCH;
          end
        endcase
      end

      ST_MEMORY: begin
        if (op_class == CLS_LD) MemRead  = 1'b1;
        else                    MemWrite = 1'b1;
        if (mem_ready) nxt_state = (op_class == CLS_LD) ? ST_WRITEBACK : ST_FETCH;
      end

      ST_WRITEBACK: begin
        ResultSrc = (op_class == CLS_LD);
        // Writing R7 redirects the PC instead, since the regfile refreshes R7 every clock.
        if (fields.rd == PC_REG) begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
        end else begin
          WE = 1'b1;
        end
        nxt_state = ST_FETCH;
      end

      default: nxt_state = ST_FETCH;
    endcase

    // Strobes stay quiet while reset is held.
    if (!rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      WE       = 1'b0;
      LRWrite  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
